// File: rtl/sync_frame_lock.sv
// PSS frame timing tracker: search/verify/lock with flywheel and miss counting.
// Optional SYNC_LOCK_TCORR_EN: accepted detects in LOCKED realign the counter.
module sync_frame_lock #(
  parameter int pDAT_W  = 12,
  parameter int pCNT_W  = 16,
  parameter int pWIN    = 8,
  parameter int pLOCK_N = 3,
  parameter int pMISS_N = 4
) (
  input  logic              iclk,
  input  logic              ireset,
  input  logic              iena,
  input  logic              isop_sync,
  input  logic [pDAT_W-1:0] icorr_mlvl,
  input  logic [pCNT_W-1:0] iperiod,
  output logic              olock,
  output logic [1:0]        ostate,
  output logic              ofsop,
  output logic [pCNT_W-1:0] otime_err,
  output logic [pDAT_W-1:0] opeak_lvl,
  output logic [2:0]        omiss_cnt
);

  localparam int HIT_W = $clog2(pLOCK_N + 1);
  localparam logic [pCNT_W-1:0] WIN = pCNT_W'(pWIN);
  localparam logic [pCNT_W-1:0] MIN_PER = pCNT_W'(2 * pWIN + 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [pCNT_W-1:0] cnt, cnt_nxt;
  logic [pCNT_W-1:0] per_r, per_nxt;
  logic [HIT_W-1:0]  hit, hit_nxt, hit_inc;
  logic              wflag, wflag_nxt;
  logic              fsop_nxt, lock_nxt;
  logic [pCNT_W-1:0] err_nxt;
  logic [pDAT_W-1:0] peak_nxt;
  logic [2:0]        miss_nxt, miss_inc;

  logic              det;
  logic [pCNT_W-1:0] lo, lmax;
  logic [pCNT_W:0]   hi;
  logic              v_in, early, late, acc;

  assign det      = iena & isop_sync;
  assign lo       = per_r - WIN;
  assign lmax     = per_r - 1'b1;
  assign hi       = {1'b0, per_r} + (pCNT_W+1)'(pWIN);
  assign v_in     = (cnt >= lo) && ({1'b0, cnt} <= hi);
  assign early    = (cnt >= lo) && (cnt <= lmax);
  assign late     = (cnt <= WIN);
  // first detect of a window; the clearing sample itself opens a new window
  assign acc      = det && (early || late) && (!wflag || cnt == lo);
  assign hit_inc  = hit + HIT_W'(1);
  assign miss_inc = omiss_cnt + 3'd1;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    per_nxt   = per_r;
    hit_nxt   = hit;
    wflag_nxt = wflag;
    fsop_nxt  = 1'b0;
    err_nxt   = otime_err;
    peak_nxt  = opeak_lvl;
    miss_nxt  = omiss_cnt;
    if (iena) begin
      unique case (state)
        SEARCH: begin
          if (det && iperiod > MIN_PER) begin
            state_nxt = VERIFY;
            cnt_nxt   = pCNT_W'(1);
            hit_nxt   = HIT_W'(1);
            peak_nxt  = icorr_mlvl;
            per_nxt   = iperiod;
          end
        end
        VERIFY: begin
          if (cnt != '1) cnt_nxt = cnt + 1'b1;
          if (det && v_in) begin
            hit_nxt  = hit_inc;
            cnt_nxt  = pCNT_W'(1);
            peak_nxt = icorr_mlvl;
            err_nxt  = cnt - per_r;
            if (hit_inc == HIT_W'(pLOCK_N)) begin
              state_nxt = LOCKED;
              fsop_nxt  = 1'b1;
              miss_nxt  = 3'd0;
              wflag_nxt = 1'b1;
            end
          end else if (det && cnt < lo) begin
            cnt_nxt  = pCNT_W'(1);
            hit_nxt  = HIT_W'(1);
            peak_nxt = icorr_mlvl;
          end else if ({1'b0, cnt} >= hi) begin
            state_nxt = SEARCH;
          end
        end
        LOCKED: begin
          cnt_nxt = (cnt == lmax) ? '0 : cnt + 1'b1;
          if (cnt == '0) fsop_nxt = 1'b1;
          if (cnt == lo) wflag_nxt = 1'b0;
          if (acc) begin
            wflag_nxt = 1'b1;
            miss_nxt  = 3'd0;
            peak_nxt  = icorr_mlvl;
            err_nxt   = early ? cnt - per_r : cnt;
`ifdef SYNC_LOCK_TCORR_EN
            cnt_nxt = pCNT_W'(1);
            if (early) fsop_nxt = 1'b1;
`endif
          end else if (cnt == WIN && !wflag) begin
            if (miss_inc == 3'(pMISS_N)) begin
              state_nxt = SEARCH;
              miss_nxt  = 3'd0;
              wflag_nxt = 1'b0;
            end else begin
              miss_nxt = miss_inc;
            end
          end
        end
        default: state_nxt = SEARCH;
      endcase
    end
    lock_nxt = (state_nxt == LOCKED);
  end

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) state <= SEARCH;
    else         state <= state_nxt;
  end

  always_ff @(posedge iclk or negedge ireset) begin
    if (!ireset) begin
      cnt       <= '0;
      per_r     <= '0;
      hit       <= '0;
      wflag     <= 1'b0;
      olock     <= 1'b0;
      ofsop     <= 1'b0;
      otime_err <= '0;
      opeak_lvl <= '0;
      omiss_cnt <= '0;
    end else begin
      cnt       <= cnt_nxt;
      per_r     <= per_nxt;
      hit       <= hit_nxt;
      wflag     <= wflag_nxt;
      olock     <= lock_nxt;
      ofsop     <= fsop_nxt;
      otime_err <= err_nxt;
      opeak_lvl <= peak_nxt;
      omiss_cnt <= miss_nxt;
    end
  end

  assign ostate = state;

endmodule

// File: tb/tb_sync_frame_lock.sv
// Directed bench for sync_frame_lock: acquire, jitter, loss, false candidate,
// reset mid-lock, period boundaries.
module tb_sync_frame_lock;

`ifdef SYNC_LOCK_TCORR_EN
  localparam bit TC = 1'b1;
`else
  localparam bit TC = 1'b0;
`endif
  localparam int OFS = TC ? 3 : 0;

  logic        iclk = 1'b0;
  logic        ireset = 1'b0;
  logic        iena = 1'b0;
  logic        isop_sync = 1'b0;
  logic [11:0] icorr_mlvl = '0;
  logic [15:0] iperiod = '0;
  logic        olock;
  logic [1:0]  ostate;
  logic        ofsop;
  logic [15:0] otime_err;
  logic [11:0] opeak_lvl;
  logic [2:0]  omiss_cnt;

  int errors = 0;
  int checks = 0;
  int n = 0;
  int b, c, e, f;

  sync_frame_lock dut (
    .iclk(iclk), .ireset(ireset), .iena(iena),
    .isop_sync(isop_sync), .icorr_mlvl(icorr_mlvl),
    .iperiod(iperiod), .olock(olock), .ostate(ostate),
    .ofsop(ofsop), .otime_err(otime_err),
    .opeak_lvl(opeak_lvl), .omiss_cnt(omiss_cnt)
  );

  always #5 iclk = ~iclk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic d, input logic [11:0] l);
    iena = 1'b1;
    isop_sync = d;
    icorr_mlvl = l;
    @(posedge iclk);
    #1;
    n++;
  endtask

  task automatic idle_to(input int t);
    while (n < t) tick(1'b0, 12'h000);
  endtask

  task automatic hold(input int k);
    iena = 1'b0;
    isop_sync = 1'b1;
    repeat (k) @(posedge iclk);
    #1;
    isop_sync = 1'b0;
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_lock"}, 32'(olock), 32'h0);
    chk({tag, "_state"}, 32'(ostate), 32'h0);
    chk({tag, "_fsop"}, 32'(ofsop), 32'h0);
    chk({tag, "_err"}, 32'(otime_err), 32'h0);
    chk({tag, "_peak"}, 32'(opeak_lvl), 32'h0);
    chk({tag, "_miss"}, 32'(omiss_cnt), 32'h0);
  endtask

  initial begin
    repeat (2) @(posedge iclk);
    #1;
    zero_chk("rst");
    ireset = 1'b1;
    iperiod = 16'd100;

    // acquire
    tick(1'b1, 12'h123);
    chk("acq0_state", 32'(ostate), 32'd1);
    chk("acq0_peak", 32'(opeak_lvl), 32'h123);
    chk("acq0_lock", 32'(olock), 32'd0);
    idle_to(100);
    tick(1'b1, 12'h200);
    chk("acq100_state", 32'(ostate), 32'd1);
    chk("acq100_err", 32'(otime_err), 32'd0);
    chk("acq100_peak", 32'(opeak_lvl), 32'h200);
    idle_to(200);
    tick(1'b1, 12'h210);
    chk("acq200_lock", 32'(olock), 32'd1);
    chk("acq200_state", 32'(ostate), 32'd2);
    chk("acq200_fsop", 32'(ofsop), 32'd1);
    tick(1'b0, 12'h000);
    chk("acq201_fsop", 32'(ofsop), 32'd0);
    idle_to(299);
    tick(1'b0, 12'h000);
    chk("fly299_fsop", 32'(ofsop), 32'd0);
    tick(1'b1, 12'h300);
    chk("fly300_fsop", 32'(ofsop), 32'd1);
    chk("fly300_err", 32'(otime_err), 32'd0);
    chk("fly300_peak", 32'(opeak_lvl), 32'h300);
    tick(1'b0, 12'h000);
    chk("fly301_fsop_once", 32'(ofsop), 32'd0);
    idle_to(400);
    tick(1'b1, 12'h400);
    chk("fly400_fsop", 32'(ofsop), 32'd1);

    // jitter
    idle_to(500);
    tick(1'b0, 12'h000);
    chk("jit500_fsop", 32'(ofsop), 32'd1);
    idle_to(503);
    tick(1'b1, 12'h3ab);
    chk("jit503_err", 32'(otime_err), 32'd3);
    chk("jit503_peak", 32'(opeak_lvl), 32'h3ab);
    chk("jit503_fsop", 32'(ofsop), 32'd0);
    idle_to(600);
    tick(1'b0, 12'h000);
    chk("jit600_fsop", 32'(ofsop), 32'(!TC));
    idle_to(603);
    tick(1'b0, 12'h000);
    chk("jit603_fsop", 32'(ofsop), 32'(TC));

    // loss of lock
    idle_to(607 + OFS);
    tick(1'b0, 12'h000);
    chk("loss_pre_miss", 32'(omiss_cnt), 32'd0);
    tick(1'b0, 12'h000);
    chk("loss_miss1", 32'(omiss_cnt), 32'd1);
    idle_to(708 + OFS);
    tick(1'b0, 12'h000);
    chk("loss_miss2", 32'(omiss_cnt), 32'd2);
    idle_to(808 + OFS);
    tick(1'b0, 12'h000);
    chk("loss_miss3", 32'(omiss_cnt), 32'd3);
    idle_to(907 + OFS);
    tick(1'b0, 12'h000);
    chk("loss_pre_lock", 32'(olock), 32'd1);
    tick(1'b0, 12'h000);
    chk("loss_state", 32'(ostate), 32'd0);
    chk("loss_lock", 32'(olock), 32'd0);
    chk("loss_miss0", 32'(omiss_cnt), 32'd0);

    // false candidate; iperiod change ignored while verifying
    b = n;
    tick(1'b1, 12'h0a1);
    iperiod = 16'd50;
    chk("fc0_state", 32'(ostate), 32'd1);
    idle_to(b + 50);
    tick(1'b1, 12'h0a2);
    chk("fc50_state", 32'(ostate), 32'd1);
    chk("fc50_peak", 32'(opeak_lvl), 32'h0a2);
    idle_to(b + 149);
    tick(1'b0, 12'h000);
    chk("fc149_state", 32'(ostate), 32'd1);
    tick(1'b1, 12'h0a3);
    chk("fc150_state", 32'(ostate), 32'd1);
    chk("fc150_lock", 32'(olock), 32'd0);
    idle_to(b + 250);
    tick(1'b1, 12'h0a4);
    chk("fc250_lock", 32'(olock), 32'd1);
    chk("fc250_fsop", 32'(ofsop), 32'd1);
    repeat (5) tick(1'b0, 12'h000);

    // reset mid-lock
    #2;
    ireset = 1'b0;
    #1;
    zero_chk("mrst");
    ireset = 1'b1;
    iperiod = 16'd64;
    c = n;
    tick(1'b1, 12'h051);
    chk("r64_0_state", 32'(ostate), 32'd1);
    idle_to(c + 66);
    tick(1'b1, 12'h052);
    chk("r64_66_state", 32'(ostate), 32'd1);
    chk("r64_66_err", 32'(otime_err), 32'd2);
    idle_to(c + 130);
    tick(1'b1, 12'h053);
    chk("r64_130_lock", 32'(olock), 32'd1);
    chk("r64_130_fsop", 32'(ofsop), 32'd1);
    chk("r64_130_err", 32'(otime_err), 32'd0);
    hold(5);
    chk("hold_fsop", 32'(ofsop), 32'd0);
    chk("hold_lock", 32'(olock), 32'd1);
    chk("hold_peak", 32'(opeak_lvl), 32'h053);
    idle_to(c + 193);
    tick(1'b0, 12'h000);
    chk("r64_193_fsop", 32'(ofsop), 32'd0);
    tick(1'b0, 12'h000);
    chk("r64_194_fsop", 32'(ofsop), 32'd1);
    idle_to(c + 256);
    tick(1'b1, 12'h054);
    chk("early_err", 32'(otime_err), 32'h0000fffe);
    chk("early_fsop", 32'(ofsop), 32'(TC));
    tick(1'b0, 12'h000);
    chk("early257_fsop", 32'(ofsop), 32'd0);
    tick(1'b0, 12'h000);
    chk("early258_fsop", 32'(ofsop), 32'(!TC));

    // boundaries
    #2;
    ireset = 1'b0;
    #1;
    ireset = 1'b1;
    iperiod = 16'd17;
    e = n;
    tick(1'b1, 12'h011);
    chk("p17_0_state", 32'(ostate), 32'd0);
    idle_to(e + 17);
    tick(1'b1, 12'h011);
    chk("p17_17_state", 32'(ostate), 32'd0);
    chk("p17_peak", 32'(opeak_lvl), 32'h0);
    iperiod = 16'd100;
    f = n;
    tick(1'b1, 12'h0b1);
    chk("to0_state", 32'(ostate), 32'd1);
    idle_to(f + 107);
    tick(1'b0, 12'h000);
    chk("to107_state", 32'(ostate), 32'd1);
    tick(1'b0, 12'h000);
    chk("to108_state", 32'(ostate), 32'd0);
    tick(1'b1, 12'h0b2);
    chk("to109_state", 32'(ostate), 32'd1);
    chk("to109_peak", 32'(opeak_lvl), 32'h0b2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sync_frame_lock.md
Name: sync_frame_lock

Overview:
Timing tracker directly downstream of the PSS correlator/detector.
- Consumes the raw detection strobe and peak level, filters false and missing detections, and flywheels the frame timing.
- Produces a clean periodic frame-start strobe, a lock indicator and a per-detection timing error for later stages (CP removal, FFT framing).
- Driven by the same sample enable as the correlator.

Parameters:
pDAT_W, 12, width of correlation peak level
pCNT_W, 16, width of sample position counter and iperiod
pWIN, 8, half-width of acceptance window, in samples
pLOCK_N, 3, consecutive in-window detections (including the first) required to lock
pMISS_N, 4, consecutive missed windows in LOCKED that force loss of lock

Ports:
iclk  in  1  clock
ireset  in  1  reset; asynchronous, active-low
iena  in  1  sample enable; all state advances only on iena=1
isop_sync  in  1  detection strobe from correlator, qualified by iena
icorr_mlvl  in  pDAT_W  peak level accompanying isop_sync
iperiod  in  pCNT_W  expected samples between PSS occurrences
olock  out  1  1 while in LOCKED
ostate  out  2  0=SEARCH, 1=VERIFY, 2=LOCKED
ofsop  out  1  one-cycle frame-start pulse
otime_err  out  pCNT_W  signed offset of last accepted detection vs. prediction
opeak_lvl  out  pDAT_W  icorr_mlvl latched at last accepted detection
omiss_cnt  out  3  consecutive missed windows in LOCKED

Behaviour:
- Reset: all outputs 0, state SEARCH, counters 0.
- Reset asserted mid-operation: immediate return to SEARCH; per_r is re-latched on the next acquisition.
- "Detect" means isop_sync=1 and iena=1. All decisions use registered outputs updated on that iena cycle.
- Latency: outputs valid in the cycle after the deciding iena.
- per_r is latched from iperiod on SEARCH->VERIFY. Changes to iperiod are ignored until the block re-enters SEARCH.
- If iperiod <= 2*pWIN+1, the block stays in SEARCH and ignores detects.
- Realignment ("cnt<=1") means the detection sample is position 0 and the next iena sample is position 1.
- SEARCH:
  - Detect -> VERIFY, cnt<=1, hit<=1, opeak_lvl latched.
- VERIFY:
  - cnt counts up on iena, with no wrap.
  - Detect with per_r-pWIN <= cnt <= per_r+pWIN is accepted: hit++, cnt<=1, opeak_lvl and otime_err = cnt-per_r latched.
  - If hit reaches pLOCK_N: -> LOCKED, ofsop pulses, omiss_cnt<=0.
  - Detect with cnt < per_r-pWIN: treated as a new candidate; cnt<=1, hit<=1, opeak_lvl latched.
  - cnt reaching per_r+pWIN without an accepted detect -> SEARCH.
- LOCKED:
  - cnt runs 0..per_r-1 and wraps. ofsop pulses for each natural position-0 sample.
  - Window = cnt in [per_r-pWIN, per_r-1] (early, err = cnt-per_r) or [0, pWIN] (late, err = cnt).
  - First detect in a window is accepted: otime_err, opeak_lvl latched; omiss_cnt<=0; window-hit flag set.
  - Further detects in the same window are ignored. Detects outside the window are ignored.
  - The window-hit flag clears when cnt = per_r-pWIN.
  - On the sample with cnt = pWIN and no hit in the current window: omiss_cnt++. On reaching pMISS_N: -> SEARCH, olock<=0, omiss_cnt<=0.
  - Detect on the same sample as a natural wrap: accepted with err = 0. ofsop is emitted exactly once.
- olock and ostate are registered and follow the state.
- otime_err is two's complement.

Optional Feature:
SYNC_LOCK_TCORR_EN
- Defined: an accepted detect in LOCKED realigns the counter (cnt<=1).
  - Early detect: ofsop pulses on the detect sample, and the pending natural wrap is skipped because the counter is realigned.
  - Late detect: no extra ofsop.
- Undefined: pure flywheel. otime_err is reported, but cnt is never modified in LOCKED.

Test Plan:
- Acquire: iena=1 continuous, iperiod=100, detects at samples 0,100,200 -> ostate 1 after sample 0; olock=1 and ofsop after sample 200; ofsop every 100 samples (300,400,...); otime_err=0.
- Jitter: locked as above, detect at 503 -> otime_err=+3. With SYNC_LOCK_TCORR_EN, next ofsop at 603; without it, at 600.
- Loss: locked, last detect at 400, none after -> omiss_cnt 1..4 at samples 508,608,708,808; ostate=0 and olock=0 the cycle after 808.
- False candidate: VERIFY after detect at 0, spurious detect at 50, then 150, 250 -> hit restarts at 50; lock after 250; ofsop at 250.
- Boundaries:
  - iperiod=17 with periodic detects -> remains SEARCH.
  - Detects at 0 and 109 (cnt=109 > per_r+pWIN=108) -> SEARCH at 108, new VERIFY at 109.
- Reset mid-lock: deassert ireset while LOCKED -> all outputs 0 immediately; reacquire with iperiod=64 -> per_r=64 used.
